// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster scan timing master for the display path. Divides the system clock
//   down to a pixel enable, runs the horizontal/vertical pixel counters and
//   decodes blanking and sync so that every output changes on the same clk
//   edge as the coordinates it describes.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active-low
//   p_tick       out  pixel enable, one clk wide, once every CLK_DIV clks
//   x            out  horizontal position 0..H_TOTAL-1
//   y            out  vertical position 0..V_TOTAL-1
//   video_on     out  high inside the visible window
//   hsync        out  horizontal sync, active level SYNC_POL
//   vsync        out  vertical sync, active level SYNC_POL
//   line_start   out  one-clk pulse when x has just wrapped to 0
//   frame_start  out  one-clk pulse when (x,y) has just wrapped to (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             h_wrap;
    logic             v_wrap;
    logic             vo_nxt;
    logic             hs_nxt;
    logic             vs_nxt;

    // Next-coordinate values; only committed on a pixel tick. Decoding from
    // these (rather than from x/y) keeps sync/blanking aligned with x/y.
    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        h_wrap  = (x == 10'(H_TOTAL - 1));
        v_wrap  = (y == 10'(V_TOTAL - 1));
        x_nxt   = h_wrap ? 10'd0 : x + 10'd1;
        y_nxt   = y;
        if (h_wrap) begin
            y_nxt = v_wrap ? 10'd0 : y + 10'd1;
        end
        vo_nxt  = (int'(x_nxt) < H_DISPLAY) && (int'(y_nxt) < V_DISPLAY);
        hs_nxt  = (int'(x_nxt) >= HS_START) && (int'(x_nxt) < HS_END);
        vs_nxt  = (int'(y_nxt) >= VS_START) && (int'(y_nxt) < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            p_tick      <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            // p_tick is high in the cycle where div_cnt holds its last value.
            p_tick      <= (div_nxt == DIV_LAST);
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (p_tick) begin
                x           <= x_nxt;
                y           <= y_nxt;
                video_on    <= vo_nxt;
                hsync       <= hs_nxt ? SYNC_ACT : ~SYNC_ACT;
                vsync       <= vs_nxt ? SYNC_ACT : ~SYNC_ACT;
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        int   n;
        logic p;
        int   x;
        int   y;
        logic vo;
        logic hs;
        logic vs;
        logic ls;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n;
    int   checks;
    int   errors;

    out_t a_def, a_sml, a_mid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .p_tick(a_def.p_tick), .x(a_def.x), .y(a_def.y),
        .video_on(a_def.vo), .hsync(a_def.hs), .vsync(a_def.vs),
        .line_start(a_def.ls), .frame_start(a_def.fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .p_tick(a_sml.p_tick), .x(a_sml.x), .y(a_sml.y),
        .video_on(a_sml.vo), .hsync(a_sml.hs), .vsync(a_sml.vs),
        .line_start(a_sml.ls), .frame_start(a_sml.fs)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(3),
        .V_DISPLAY(5), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(0)
    ) u_mid (
        .clk(clk), .rst_n(rst_n), .p_tick(a_mid.p_tick), .x(a_mid.x), .y(a_mid.y),
        .video_on(a_mid.vo), .hsync(a_mid.hs), .vsync(a_mid.vs),
        .line_start(a_mid.ls), .frame_start(a_mid.fs)
    );

    // Pixel ticks consumed after n clk edges since reset release.
    function automatic int ticks(int d, int k);
        if (k <= 0) return 0;
        if (d == 1) return k - 1;
        return k / d;
    endfunction

    // Reference: everything follows from the number of elapsed pixel ticks.
    function automatic out_t model(int d, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb, logic pol, int k);
        out_t o;
        int ht = hd + hf + hs + hb;
        int vt = vd + vf + vs + vb;
        int t  = ticks(d, k);
        int tp = ticks(d, k - 1);
        int xv = t % ht;
        int yv = (t / ht) % vt;
        o.p_tick = (k >= 1) && ((k % d) == d - 1);
        o.x      = 10'(xv);
        o.y      = 10'(yv);
        o.vo     = (t >= 1) && (xv < hd) && (yv < vd);
        o.hs     = (xv >= hd + hf && xv < hd + hf + hs) ? pol : ~pol;
        o.vs     = (yv >= vd + vf && yv < vd + vf + vs) ? pol : ~pol;
        o.ls     = (k >= 1) && (t != tp) && (xv == 0);
        o.fs     = o.ls && (yv == 0);
        return o;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", nm, act, exp, n, $time);
        end
    endtask

    task automatic check_inst(string tag, out_t act, out_t exp);
        chk({tag, ".p_tick"},      32'(act.p_tick), 32'(exp.p_tick));
        chk({tag, ".x"},           32'(act.x),      32'(exp.x));
        chk({tag, ".y"},           32'(act.y),      32'(exp.y));
        chk({tag, ".video_on"},    32'(act.vo),     32'(exp.vo));
        chk({tag, ".hsync"},       32'(act.hs),     32'(exp.hs));
        chk({tag, ".vsync"},       32'(act.vs),     32'(exp.vs));
        chk({tag, ".line_start"},  32'(act.ls),     32'(exp.ls));
        chk({tag, ".frame_start"}, 32'(act.fs),     32'(exp.fs));
    endtask

    task automatic check_all();
        check_inst("def", a_def, model(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n));
        check_inst("sml", a_sml, model(1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, n));
        check_inst("mid", a_mid, model(3, 10, 3, 4, 3, 5, 2, 2, 3, 1'b0, n));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst_n) n++;
        check_all();
    endtask

    // Asserts reset between clock edges and checks the async clear at once.
    task automatic do_reset(int hold, int offs);
        #(offs);
        rst_n = 1'b0;
        #1;
        n = 0;
        check_all();
        repeat (hold) cyc();
        rst_n = 1'b1;
    endtask

    vec_t vecs[$];
    int   vcnt, vscnt, fscnt;

    initial begin
        checks = 0;
        errors = 0;
        n      = 0;
        rst_n  = 1'b0;

        // n, p_tick, x, y, video_on, hsync, vsync, line_start (default instance)
        vecs.push_back('{0,    1'b0, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3,    1'b1, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4,    1'b0, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8,    1'b0, 2,   0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{2559, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{2560, 1'b0, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{2623, 1'b1, 655, 0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{2624, 1'b0, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3007, 1'b1, 751, 0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3008, 1'b0, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3200, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{3201, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3203, 1'b1, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3204, 1'b0, 1,   1, 1'b1, 1'b1, 1'b1, 1'b0});

        // Reset held 5 clks, then walk the table.
        repeat (5) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            while (n < vecs[i].n) cyc();
            chk("tab.p_tick",     32'(a_def.p_tick), 32'(vecs[i].p));
            chk("tab.x",          32'(a_def.x),      32'(vecs[i].x));
            chk("tab.y",          32'(a_def.y),      32'(vecs[i].y));
            chk("tab.video_on",   32'(a_def.vo),     32'(vecs[i].vo));
            chk("tab.hsync",      32'(a_def.hs),     32'(vecs[i].hs));
            chk("tab.vsync",      32'(a_def.vs),     32'(vecs[i].vs));
            chk("tab.line_start", 32'(a_def.ls),     32'(vecs[i].ls));
        end

        // Mid-line reset at x=300: async clear, then restart from (0,0).
        do_reset(3, 0);
        while (n < 1200) cyc();
        chk("mid.x_before", 32'(a_def.x), 32'd300);
        do_reset(2, 2);
        chk("mid.x_reset", 32'(a_def.x), 32'd0);
        chk("mid.hsync_reset", 32'(a_def.hs), 32'd1);
        repeat (4) cyc();
        chk("mid.x_resume", 32'(a_def.x), 32'd1);

        // Small instance: aggregate counts over its second full frame.
        do_reset(2, 0);
        vcnt = 0; vscnt = 0; fscnt = 0;
        while (n < 240) begin
            cyc();
            if (n > 120) begin
                if (a_sml.p_tick && a_sml.vo) vcnt++;
                if (a_sml.vs) vscnt++;
                if (a_sml.fs) fscnt++;
            end
        end
        chk("sml.video_ticks", 32'(vcnt), 32'd32);
        chk("sml.vsync_ticks", 32'(vscnt), 32'd30);
        chk("sml.frame_starts", 32'(fscnt), 32'd1);

        // Randomized run lengths and reset timing.
        for (int r = 0; r < 12; r++) begin
            int len = $urandom_range(1, 1500);
            repeat (len) cyc();
            do_reset($urandom_range(1, 4), $urandom_range(0, 3));
        end
        repeat (50) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
